// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier / accumulator back end.
//   PROD_W_DEF : product width produced by mbooth4bit; the accumulator uses it
//                as its default so both blocks stay aligned.
//   state_t    : accumulator FSM state encoding.
package booth_pkg;

  localparam int PROD_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mac_acc_if.sv
// Bus bundle between the operand stage / consumer and booth_mac_acc.
//   start, len           : job request and length (sampled only in IDLE)
//   in_valid/in_ready    : product stream, prod carries the signed product
//   out_valid/out_ready  : result stream, acc_out/overflow carry the result
//   busy                 : block is not in IDLE
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised, the payload
// must stay stable until that transfer. Ready never depends combinationally
// on valid.
// master: drives requests, products and out_ready.
// slave : the accumulator.
interface booth_mac_acc_if #(
  parameter int PROD_W = booth_pkg::PROD_W_DEF,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 5
);

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic              busy;

  modport master (
    output start, len, in_valid, prod, out_ready,
    input  in_ready, out_valid, acc_out, overflow, busy
  );

  modport slave (
    input  start, len, in_valid, prod, out_ready,
    output in_ready, out_valid, acc_out, overflow, busy
  );

endinterface

// File: rtl/booth_mac_acc_add.sv
// acc_add: combinational ACC_W-bit two's-complement adder with signed
// overflow detection.
//   a, b : addends (b is the already sign-extended product)
//   sum  : a + b modulo 2^ACC_W
//   ovf  : high when a and b share a sign and sum's sign differs
module acc_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  assign sum = a + b;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);

endmodule

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: sums a programmed number of signed Booth products into a
// wider accumulator and returns one result per job.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : booth_mac_acc_if slave (job request, product stream,
//                result stream, busy). Its parameters must match the ones
//                given here.
//   state_dbg  : current FSM state, for observation only
// All outputs are flops. in_ready/out_valid/busy are registered copies of
// the state decode, updated together with the state register.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mac_acc_if.slave  bus,
  output state_t          state_dbg
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_nxt;

  // Size cast of a signed value sign-extends (works for ACC_W == PROD_W too).
  assign prod_ext = ACC_W'($signed(bus.prod));
  assign cnt_nxt  = cnt + CNT_W'(1);

  acc_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      ovf_q       <= 1'b0;
      cnt         <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q  <= bus.len;
            acc    <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              state      <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              // Empty job: report a zero result straight away.
              state       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= sum;
            cnt <= cnt_nxt;
            if (add_ovf) ovf_q <= 1'b1;
            if (cnt_nxt == len_q) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: a 16-bit accumulator instance for the
// functional jobs and an 8-bit instance for the overflow case.
module tb_booth_mac_acc;
  import booth_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t st;
  state_t st_o;

  booth_mac_acc_if #(.ACC_W(16)) b  ();
  booth_mac_acc_if #(.ACC_W(8))  bo ();

  booth_mac_acc #(.ACC_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (b.slave),
    .state_dbg (st)
  );

  booth_mac_acc #(.ACC_W(8)) dut_o (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bo.slave),
    .state_dbg (st_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [4:0] n, input logic [15:0] exp_res);
    b.start = 1'b1;
    b.len   = n;
    exp_q.push_back(exp_res);
    step();
    b.start = 1'b0;
  endtask

  task automatic send_prod(input logic [7:0] p);
    b.in_valid = 1'b1;
    b.prod     = p;
    step();
    b.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, checks against the scoreboard and
  // completes the result handshake.
  task automatic take_result(input string tag);
    int n;
    logic [15:0] e;
    n = 0;
    while (!b.out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_out_valid"}, 32'(b.out_valid), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hdead;
    check({tag, "_acc"}, 32'(b.acc_out), 32'(e));
    b.out_ready = 1'b1;
    step();
    b.out_ready = 1'b0;
    check({tag, "_idle"}, 32'(st), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    b.start = 1'b0;  b.len = '0;  b.in_valid = 1'b0;  b.prod = '0;  b.out_ready = 1'b0;
    bo.start = 1'b0; bo.len = '0; bo.in_valid = 1'b0; bo.prod = '0; bo.out_ready = 1'b0;
    step();
    step();
    check("rst_state", 32'(st), 32'(IDLE));
    check("rst_acc", 32'(b.acc_out), 32'd0);
    check("rst_flags", {28'd0, b.in_ready, b.out_valid, b.overflow, b.busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic job: 49 - 56 - 6 = -13
    start_job(5'd3, 16'hFFF3);
    check("basic_accum", 32'(st), 32'(ACCUM));
    check("basic_in_ready", 32'(b.in_ready), 32'd1);
    check("basic_busy", 32'(b.busy), 32'd1);
    send_prod(8'h31);
    send_prod(8'hC8);
    check("basic_not_done", 32'(b.out_valid), 32'd0);
    send_prod(8'hFA);
    check("basic_latency", 32'(b.out_valid), 32'd1);
    check("basic_in_ready_low", 32'(b.in_ready), 32'd0);
    check("basic_ovf", 32'(b.overflow), 32'd0);
    take_result("basic");
    check("basic_acc_kept", 32'(b.acc_out), 32'hFFF3);
    check("basic_busy_low", 32'(b.busy), 32'd0);

    // Empty job: result in the cycle after start, in_ready never high
    start_job(5'd0, 16'h0000);
    check("empty_latency", 32'(b.out_valid), 32'd1);
    check("empty_in_ready", 32'(b.in_ready), 32'd0);
    take_result("empty");

    // Input stall and output backpressure
    start_job(5'd2, 16'h0020);
    send_prod(8'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", {b.in_ready, b.out_valid, b.acc_out}, {1'b1, 1'b0, 16'h0010});
    end
    send_prod(8'h10);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {b.out_valid, b.acc_out}, {1'b1, 16'h0020});
      step();
    end
    take_result("bp");

    // start while busy is ignored (in ACCUM and in DONE)
    start_job(5'd2, 16'h0008);
    send_prod(8'h05);
    b.start = 1'b1;
    b.len   = 5'd5;
    send_prod(8'h03);
    check("busy_start_done", 32'(st), 32'(DONE));
    step();
    b.start = 1'b0;
    check("busy_start_stay", 32'(st), 32'(DONE));
    take_result("busy_start");

    // Reset mid-job, then a clean len=1 job
    start_job(5'd3, 16'h0007);
    send_prod(8'h22);
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(st), 32'(IDLE));
    check("midrst_acc", 32'(b.acc_out), 32'd0);
    check("midrst_flags", {28'd0, b.in_ready, b.out_valid, b.overflow, b.busy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    start_job(5'd1, 16'h0007);
    send_prod(8'h07);
    // The first pushed expectation belonged to the aborted job.
    void'(exp_q.pop_front());
    take_result("after_rst");

    // Overflow on the 8-bit accumulator: 0x40 + 0x40 = 0x80
    bo.start = 1'b1;
    bo.len   = 5'd2;
    step();
    bo.start = 1'b0;
    check("ovf_in_ready", 32'(bo.in_ready), 32'd1);
    bo.in_valid = 1'b1;
    bo.prod     = 8'h40;
    step();
    check("ovf_first_clear", 32'(bo.overflow), 32'd0);
    step();
    bo.in_valid = 1'b0;
    check("ovf_valid", 32'(bo.out_valid), 32'd1);
    check("ovf_acc", 32'(bo.acc_out), 32'h80);
    check("ovf_flag", 32'(bo.overflow), 32'd1);
    bo.out_ready = 1'b1;
    step();
    bo.out_ready = 1'b0;
    check("ovf_sticky", 32'(bo.overflow), 32'd1);
    bo.start = 1'b1;
    bo.len   = 5'd1;
    step();
    bo.start = 1'b0;
    check("ovf_cleared", {bo.overflow, bo.acc_out}, {1'b0, 8'h00});
    check("ovf_busy", 32'(bo.busy), 32'd1);
    bo.in_valid = 1'b1;
    bo.prod     = 8'hFF;
    step();
    bo.in_valid = 1'b0;
    check("neg_acc", {bo.out_valid, bo.overflow, bo.acc_out}, {1'b1, 1'b0, 8'hFF});
    check("neg_state", 32'(st_o), 32'(DONE));
    bo.out_ready = 1'b1;
    step();
    bo.out_ready = 1'b0;

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mac_acc.md
# booth_mac_acc

Signed multiply-accumulate back end that consumes the 8-bit two's-complement products of the 4-bit radix-4 Booth multiplier (`mbooth4bit`) and sums a programmed number of them into a wider accumulator. It sits directly downstream of the multiplier. The upstream operand stage presents each product together with `in_valid`. The block returns one registered dot-product result per job over a valid/ready output handshake.

## Interface

Parameters:
- PROD_W, 8, product width (matches the multiplier output `p`)
- ACC_W, 16, accumulator width; must be ≥ PROD_W
- CNT_W, 5, width of the job length and element counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- len  in  CNT_W  number of products in the job; sampled with start
- in_valid  in  1  prod is valid this cycle
- in_ready  out  1  block accepts prod this cycle
- prod  in  PROD_W  signed product from the Booth multiplier
- out_valid  out  1  acc_out/overflow hold a completed result
- out_ready  in  1  consumer accepts the result
- acc_out  out  ACC_W  signed accumulated sum
- overflow  out  1  sticky signed-overflow flag for the current job
- busy  out  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, ACCUM, DONE. The state is registered.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - start=1 latches len into len_q, clears the accumulator, the counter cnt and overflow.
  - If len≠0, the next state is ACCUM; if len=0, the next state is DONE (result 0).
- ACCUM:
  - in_ready=1 (a decode of the state only; no combinational path from in_valid).
  - Each in_valid&in_ready handshake:
    - acc ← acc + sign_extend(prod).
    - cnt ← cnt+1.
    - overflow is set when both addends share a sign and the sum's sign differs.
  - The sum wraps modulo 2^ACC_W. overflow remains set until the next start or reset.
  - The handshake that brings cnt to len_q moves the FSM to DONE.
  - in_valid low stalls the job with no state change.
- DONE:
  - out_valid=1; acc_out and overflow hold stable until out_valid&out_ready, then the FSM returns to IDLE.
  - in_ready=0.
- start outside IDLE is ignored (no restart, no queueing).
- acc_out is the accumulator register itself. It remains readable after the result handshake and is cleared only by the next start or by reset.
- Reset values: state=IDLE, acc_out=0, overflow=0, cnt=0, len_q=0, in_ready=0, out_valid=0, busy=0.
- rst_n asserted at any point, including mid-job or while out_valid is high, returns the block to the reset values immediately. The partial result is discarded.

## Timing

- start to first possible product acceptance: 1 cycle (ACCUM is entered on the edge after start).
- Throughput: one product per cycle while in_valid is held high.
- Last accepted product to out_valid=1: 1 cycle. acc_out is valid in the same cycle that out_valid rises.
- len=0: out_valid=1 in the cycle after start.
- Result handshake to IDLE: 1 cycle. A new start is accepted in the IDLE cycle, so there are two cycles of overhead between jobs.
- All outputs are registered or decoded from the registered state. No input-to-output combinational paths.

## Structure

- Shared package `booth_pkg` holds:
  - the state enum (IDLE, ACCUM, DONE);
  - the PROD_W default, so the multiplier and accumulator widths stay aligned.
- One sub-module, `acc_add`, is natural:
  - a combinational ACC_W-bit adder;
  - takes the sign-extended prod as an input;
  - produces sum and the signed-overflow bit.
- The top level holds the FSM, counter and registers.

## Test plan

- **Basic job:**
  - Stimulus: len=3, products 0x31 (+49), 0xC8 (−56), 0xFA (−6) on consecutive cycles.
  - Response: out_valid one cycle after the third product, acc_out=0xFFF3 (−13), overflow=0.
- **Empty job:**
  - Stimulus: len=0.
  - Response: out_valid=1 in the cycle after start, acc_out=0x0000, in_ready never asserted.
- **Input stall and output backpressure:**
  - Stimulus: len=2; in_valid low for 3 cycles between the two products 0x10 and 0x10; out_ready low for 5 cycles.
  - Response: acc_out=0x0020 held stable with out_valid high until out_ready rises; FSM returns to IDLE one cycle later.
- **Overflow (ACC_W=8):**
  - Stimulus: len=2, products 0x40 and 0x40.
  - Response: acc_out=0x80, overflow=1; overflow clears on the next start.
- **start while busy:**
  - Stimulus: assert start with len=5 during an ACCUM job of len=2.
  - Response: ignored; the job completes after 2 products with an unchanged result.
- **Reset mid-job:**
  - Stimulus: rst_n low after 1 of 3 products.
  - Response: all outputs are at reset values in the same cycle; a following len=1 job with product 0x07 yields acc_out=0x0007.
